eth_tx_stage_seq: RTL

Transmit-side stage sequencer for the Ethernet MAC encapsulation path. It accepts a frame start with a payload length, then walks the one-hot frame stages: preamble, SFD, header, payload, pad, FCS, inter-frame gap. It counts bytes within each stage and advances only on a byte-accept strobe from the downstream byte serializer. Its one-hot stage vector and byte index drive the encapsulation datapath muxes (preamble constant, header ROM/regs, payload FIFO read, pad zeros, CRC output).

---
 rtl/eth_tx_stage_seq_if.sv | 20 ++
 rtl/eth_tx_stage_seq.sv | 86 ++++++++
 2 files changed

// File: rtl/eth_tx_stage_seq_if.sv
// eth_tx_stage_seq_if: frame request, byte handshake and stage status bundle
interface eth_tx_stage_seq_if #(parameter int LEN_W = 11);
  logic start;
  logic [LEN_W-1:0] payload_len;
  logic byte_rdy;
  logic [6:0] stage;
  logic [LEN_W-1:0] byte_idx;
  logic last_byte;
  logic busy;
  logic done;
  logic len_err;
  modport master (
    output start, payload_len, byte_rdy,
    input stage, byte_idx, last_byte, busy, done, len_err
  );
  modport slave (
    input start, payload_len, byte_rdy,
    output stage, byte_idx, last_byte, busy, done, len_err
  );
endinterface

// File: rtl/eth_tx_stage_seq.sv
// eth_tx_stage_seq: one-hot Ethernet transmit stage sequencer with per-stage byte index
module eth_tx_stage_seq #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_BYTES = 12,
  parameter int LEN_W = 11
) (
  input logic clk,
  input logic rst,
  eth_tx_stage_seq_if.slave bus
);
  typedef enum logic [6:0] {
    IDLE = 7'h00,
    PRE = 7'h01,
    SFD = 7'h02,
    HDR = 7'h04,
    PL = 7'h08,
    PAD = 7'h10,
    FCS = 7'h20,
    IFG = 7'h40
  } state_t;
  state_t st, nxt;
  logic [LEN_W-1:0] idx, len_q, pad_q, slen;
  logic last, done_q, len_err_q;
  // length of the stage currently being emitted
  always_comb begin
    slen = st == PRE ? LEN_W'(7) :
           st == SFD ? LEN_W'(1) :
           st == HDR ? LEN_W'(14) :
           st == PL ? len_q :
           st == PAD ? pad_q :
           st == FCS ? LEN_W'(4) :
           st == IFG ? LEN_W'(IFG_BYTES) : '0;
    last = (st != IDLE) && (idx == slen - 1'b1);
  end
  // next non-empty stage; empty PAYLOAD/PAD are skipped without a dead cycle
  always_comb begin
    nxt = IDLE;
    case (st)
      PRE: nxt = SFD;
      SFD: nxt = HDR;
      HDR: nxt = len_q != '0 ? PL : pad_q != '0 ? PAD : FCS;
      PL: nxt = pad_q != '0 ? PAD : FCS;
      PAD: nxt = FCS;
      FCS: nxt = IFG;
      default: nxt = IDLE;
    endcase
  end
  // frame capture, byte stepping and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      idx <= '0;
      len_q <= '0;
      pad_q <= '0;
      done_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      len_err_q <= 1'b0;
      if (st == IDLE) begin
        if (bus.start && bus.payload_len <= LEN_W'(MAX_PAYLOAD)) begin
          st <= PRE;
          len_q <= bus.payload_len;
          pad_q <= bus.payload_len < LEN_W'(MIN_PAYLOAD) ? LEN_W'(MIN_PAYLOAD) - bus.payload_len : '0;
        end else if (bus.start) begin
          len_err_q <= 1'b1;
        end
      end else if (bus.byte_rdy) begin
        if (last) begin
          st <= nxt;
          idx <= '0;
          done_q <= st == IFG;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
  assign bus.stage = st;
  assign bus.byte_idx = idx;
  assign bus.last_byte = last;
  assign bus.busy = st != IDLE;
  assign bus.done = done_q;
  assign bus.len_err = len_err_q;
endmodule
